// File: rtl/ahb_uart_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_uart_pkg
// Brief    : Shared AHB-lite encodings, UART register offsets, FSM state and
//            job-kind encodings for the UART sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package ahb_uart_pkg;

  // AHB-lite transfer attributes used by this single-master sequencer
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  // UART register offsets from the peripheral base
  localparam logic [3:0] UART_DATA = 4'h0;
  localparam logic [3:0] UART_CTRL = 4'h4;
  localparam logic [3:0] UART_BAUD = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    JOB_BAUD = 2'd0,
    JOB_CTRL = 2'd1,
    JOB_RD   = 2'd2,
    JOB_WR   = 2'd3
  } job_t;

  // Base has zero low nibble, so OR-ing the offset is an exact add
  function automatic logic [31:0] uart_addr(input logic [31:0] base, input logic [3:0] off);
    return base | {28'b0, off};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_uart_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_uart_sched_if
// Brief    : AHB-lite point-to-point link between the sequencer (master) and
//            the UART slave port.
// Revision : 1.0 - initial release
// ============================================================================
interface ahb_uart_sched_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              hsel_o;
  logic [AWIDTH-1:0] haddr_o;
  logic              hwrite_o;
  logic [2:0]        hsize_o;
  logic [2:0]        hburst_o;
  logic [1:0]        htrans_o;
  logic [DWIDTH-1:0] hwdata_o;
  logic              hready_i;
  logic              hresp_i;
  logic [DWIDTH-1:0] hrdata_i;

  modport master (
    output hsel_o, haddr_o, hwrite_o, hsize_o, hburst_o, htrans_o, hwdata_o,
    input  hready_i, hresp_i, hrdata_i
  );

  modport slave (
    input  hsel_o, haddr_o, hwrite_o, hsize_o, hburst_o, htrans_o, hwdata_o,
    output hready_i, hresp_i, hrdata_i
  );
endinterface
`default_nettype wire

// File: rtl/ahb_uart_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : NREQ-wide round-robin arbiter. Search starts one past the last
//            winner; the pointer moves to the winner when i_en accepts it.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  wire logic            hclk,
  input  wire logic            hreset,
  input  wire logic [NREQ-1:0] i_req,
  input  wire logic            i_en,
  output logic      [NREQ-1:0] o_gnt,
  output logic                 o_any
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDXW-1:0] r_ptr;
  logic [NREQ-1:0] w_mask;
  logic [NREQ-1:0] w_hi;
  logic [IDXW-1:0] w_idx;

  // Lowest requester above the pointer wins, else wrap to lowest overall
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_mask[i] = (i > int'(r_ptr));
    end
    w_hi  = i_req & w_mask;
    w_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req[i]) w_idx = i[IDXW-1:0];
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_hi[i]) w_idx = i[IDXW-1:0];
    end
    o_any = |i_req;
    o_gnt = o_any ? (NREQ'(1) << w_idx) : '0;
  end

  // Pointer remembers the last accepted winner
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_ptr <= IDXW'(NREQ - 1);
    end else if (i_en && o_any) begin
      r_ptr <= w_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_uart_sched.sv
`default_nettype none
// ============================================================================
// Module   : ahb_uart_sched
// Brief    : AHB-lite single-master sequencer owning the UART. Programs baud
//            and control after reset, then serves RX reads and round-robin TX
//            byte writes as single NONSEQ word transfers.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_uart_sched
  import ahb_uart_pkg::*;
#(
  parameter int          NREQ      = 2,
  parameter int          AWIDTH    = 32,
  parameter int          DWIDTH    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] BAUD_INIT = 32'h1B2,
  parameter logic [7:0]  CTRL_INIT = 8'h03
) (
  input  wire logic              hclk,
  input  wire logic              hreset,
  ahb_uart_sched_if.master       bus,
  input  wire logic [NREQ-1:0]   req_valid_i,
  input  wire logic [8*NREQ-1:0] req_data_i,
  output logic      [NREQ-1:0]   req_ready_o,
  input  wire logic              rx_req_i,
  output logic                   rx_valid_o,
  output logic      [7:0]        rx_data_o,
  input  wire logic              cfg_we_i,
  input  wire logic [31:0]       cfg_baud_i,
  output logic                   init_done_o,
  output logic                   busy_o,
  output logic                   err_o
);

  state_t            r_state;
  job_t              r_job;
  logic              r_hsel;
  logic [1:0]        r_htrans;
  logic [AWIDTH-1:0] r_haddr;
  logic              r_hwrite;
  logic [DWIDTH-1:0] r_hwdata;
  logic [DWIDTH-1:0] r_wdata;
  logic [NREQ-1:0]   r_req_ready;
  logic              r_rx_valid;
  logic [7:0]        r_rx_data;
  logic              r_init_done;
  logic              r_err;
  logic              r_pend_baud;
  logic              r_pend_ctrl;
  logic [31:0]       r_baud_q;
  logic              r_cfg_hit;

  logic              w_launch;
  job_t              w_job;
  logic [AWIDTH-1:0] w_addr;
  logic [DWIDTH-1:0] w_wdata;
  logic              w_arb_en;
  logic [NREQ-1:0]   w_gnt;
  logic              w_any;
  logic [7:0]        w_byte;
  logic              w_baud_live;
  logic              w_unused;

  // Upper read-data bits carry nothing for byte-wide RX
  assign w_unused = ^bus.hrdata_i[DWIDTH-1:8];

  // TX only competes when no higher-priority job exists and init has finished
  assign w_arb_en = (r_state == ST_IDLE) && !r_pend_baud && !r_pend_ctrl &&
                    !rx_req_i && r_init_done;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .hclk   (hclk),
    .hreset (hreset),
    .i_req  (req_valid_i),
    .i_en   (w_arb_en),
    .o_gnt  (w_gnt),
    .o_any  (w_any)
  );

  // Byte of the granted requester
  always_comb begin
    w_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) w_byte = req_data_i[8*i +: 8];
    end
  end

  // Fixed-priority job selection in IDLE: baud, ctrl, RX read, TX write
  always_comb begin
    w_launch = 1'b0;
    w_job    = JOB_BAUD;
    w_addr   = '0;
    w_wdata  = '0;
    if (r_pend_baud) begin
      w_launch = 1'b1;
      w_job    = JOB_BAUD;
      w_addr   = AWIDTH'(uart_addr(BASE_ADDR, UART_BAUD));
      w_wdata  = DWIDTH'(r_baud_q);
    end else if (r_pend_ctrl) begin
      w_launch = 1'b1;
      w_job    = JOB_CTRL;
      w_addr   = AWIDTH'(uart_addr(BASE_ADDR, UART_CTRL));
      w_wdata  = DWIDTH'(CTRL_INIT);
    end else if (rx_req_i) begin
      w_launch = 1'b1;
      w_job    = JOB_RD;
      w_addr   = AWIDTH'(uart_addr(BASE_ADDR, UART_DATA));
    end else if (r_init_done && w_any) begin
      w_launch = 1'b1;
      w_job    = JOB_WR;
      w_addr   = AWIDTH'(uart_addr(BASE_ADDR, UART_DATA));
      w_wdata  = DWIDTH'(w_byte);
    end
  end

  // A baud write is in flight (or launching now) and has latched the old value
  assign w_baud_live = ((r_state == ST_ADDR || r_state == ST_DATA) && r_job == JOB_BAUD) ||
                       (r_state == ST_IDLE && w_launch && w_job == JOB_BAUD);

  // Sequencer FSM with registered bus and status outputs
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state     <= ST_IDLE;
      r_job       <= JOB_BAUD;
      r_hsel      <= 1'b0;
      r_htrans    <= HTRANS_IDLE;
      r_haddr     <= '0;
      r_hwrite    <= 1'b0;
      r_hwdata    <= '0;
      r_wdata     <= '0;
      r_req_ready <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= '0;
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
      r_pend_baud <= 1'b1;
      r_pend_ctrl <= 1'b1;
      r_baud_q    <= BAUD_INIT;
      r_cfg_hit   <= 1'b0;
    end else begin
      r_req_ready <= '0;
      r_rx_valid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_state   <= ST_ADDR;
            r_job     <= w_job;
            r_hsel    <= 1'b1;
            r_htrans  <= HTRANS_NONSEQ;
            r_haddr   <= w_addr;
            r_hwrite  <= (w_job != JOB_RD);
            r_wdata   <= w_wdata;
            r_cfg_hit <= 1'b0;
            if (w_job == JOB_WR) r_req_ready <= w_gnt;
          end
        end
        ST_ADDR: begin
          r_state  <= ST_DATA;
          r_htrans <= HTRANS_IDLE;
          r_hwdata <= r_wdata;
        end
        ST_DATA: begin
          if (bus.hready_i) begin
            r_state <= ST_GAP;
            r_hsel  <= 1'b0;
            case (r_job)
              JOB_RD: begin
                r_rx_data  <= bus.hrdata_i[7:0];
                r_rx_valid <= 1'b1;
              end
              JOB_BAUD: r_pend_baud <= r_cfg_hit;
              JOB_CTRL: begin
                r_pend_ctrl <= 1'b0;
                r_init_done <= 1'b1;
              end
              default: ;
            endcase
            if (bus.hresp_i) r_err <= 1'b1;
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      // Reprogram request: last value wins, and an in-flight baud write
      // carrying the stale value must not retire the pending flag
      if (cfg_we_i) begin
        r_baud_q    <= cfg_baud_i;
        r_pend_baud <= 1'b1;
        if (w_baud_live) r_cfg_hit <= 1'b1;
      end
    end
  end

  assign bus.hsel_o   = r_hsel;
  assign bus.haddr_o  = r_haddr;
  assign bus.hwrite_o = r_hwrite;
  assign bus.hsize_o  = HSIZE_WORD;
  assign bus.hburst_o = HBURST_SINGLE;
  assign bus.htrans_o = r_htrans;
  assign bus.hwdata_o = r_hwdata;

  assign req_ready_o = r_req_ready;
  assign rx_valid_o  = r_rx_valid;
  assign rx_data_o   = r_rx_data;
  assign init_done_o = r_init_done;
  assign err_o       = r_err;
  assign busy_o      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ahb_uart_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_uart_sched
// Brief    : Directed self-checking bench for ahb_uart_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_uart_sched;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        hclk;
  logic        hreset;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        rx_req;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cfg_we;
  logic [31:0] cfg_baud;
  logic        init_done;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;

  ahb_uart_sched_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  ahb_uart_sched #(
    .NREQ(2), .AWIDTH(32), .DWIDTH(32),
    .BASE_ADDR(32'h3000_0000), .BAUD_INIT(32'h1B2), .CTRL_INIT(8'h03)
  ) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .bus         (bus),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .rx_req_i    (rx_req),
    .rx_valid_o  (rx_valid),
    .rx_data_o   (rx_data),
    .cfg_we_i    (cfg_we),
    .cfg_baud_i  (cfg_baud),
    .init_done_o (init_done),
    .busy_o      (busy),
    .err_o       (err)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_hsel"},   64'(bus.hsel_o),   64'(0));
    chk({tag, "_htrans"}, 64'(bus.htrans_o), 64'(0));
    chk({tag, "_haddr"},  64'(bus.haddr_o),  64'(0));
    chk({tag, "_hwrite"}, 64'(bus.hwrite_o), 64'(0));
    chk({tag, "_hwdata"}, 64'(bus.hwdata_o), 64'(0));
    chk({tag, "_rdy"},    64'(req_ready),    64'(0));
    chk({tag, "_rxv"},    64'(rx_valid),     64'(0));
    chk({tag, "_rxd"},    64'(rx_data),      64'(0));
    chk({tag, "_init"},   64'(init_done),    64'(0));
    chk({tag, "_err"},    64'(err),          64'(0));
    chk({tag, "_busy"},   64'(busy),         64'(0));
  endtask

  task automatic chk_addr(input string tag, input logic [31:0] addr, input logic wr);
    chk({tag, "_hsel"},   64'(bus.hsel_o),   64'(1));
    chk({tag, "_htrans"}, 64'(bus.htrans_o), 64'(2'b10));
    chk({tag, "_haddr"},  64'(bus.haddr_o),  64'(addr));
    chk({tag, "_hwrite"}, 64'(bus.hwrite_o), 64'(wr));
  endtask

  initial begin
    hreset    = 1'b1;
    req_valid = 2'b00;
    req_data  = {8'h42, 8'h41};
    rx_req    = 1'b0;
    cfg_we    = 1'b0;
    cfg_baud  = 32'h0;
    bus.hready_i = 1'b1;
    bus.hresp_i  = 1'b0;
    bus.hrdata_i = 32'h0;

    // Reset state
    tick();
    tick();
    chk_reset("rst");
    hreset = 1'b0;

    // Init: baud write at cycle 1, ctrl write at cycle 5
    tick();
    chk_addr("baud_a", BASE + 32'h8, 1'b1);
    chk("baud_a_busy",  64'(busy),         64'(1));
    chk("baud_a_hsize", 64'(bus.hsize_o),  64'(3'b010));
    chk("baud_a_hbst",  64'(bus.hburst_o), 64'(3'b000));
    tick();
    chk("baud_d_htrans", 64'(bus.htrans_o), 64'(0));
    chk("baud_d_hsel",   64'(bus.hsel_o),   64'(1));
    chk("baud_d_hwdata", 64'(bus.hwdata_o), 64'(32'h1B2));
    tick();
    chk("baud_gap_hsel", 64'(bus.hsel_o), 64'(0));
    chk("baud_gap_init", 64'(init_done),  64'(0));
    tick();
    chk("init_idle_busy", 64'(busy), 64'(0));
    tick();
    chk_addr("ctrl_a", BASE + 32'h4, 1'b1);
    tick();
    chk("ctrl_d_hwdata", 64'(bus.hwdata_o), 64'(32'h03));
    tick();
    chk("ctrl_gap_hsel", 64'(bus.hsel_o), 64'(0));
    chk("ctrl_gap_init", 64'(init_done),  64'(1));

    // Two requesters held: grants alternate 0,1,0,1 every 4 cycles
    req_valid = 2'b11;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_addr("tx_a", BASE, 1'b1);
      chk("tx_a_rdy", 64'(req_ready), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      if (k == 3) req_valid = 2'b00;
      tick();
      chk("tx_d_rdy",    64'(req_ready),    64'(0));
      chk("tx_d_hwdata", 64'(bus.hwdata_o), (k % 2 == 0) ? 64'(8'h41) : 64'(8'h42));
      tick();
      chk("tx_gap_hsel", 64'(bus.hsel_o), 64'(0));
      tick();
    end

    // Stalled TX data phase: 10 cycles with hready low
    req_valid = 2'b01;
    tick();
    chk("stall_a_rdy", 64'(req_ready), 64'(2'b01));
    req_valid    = 2'b00;
    bus.hready_i = 1'b0;
    tick();
    chk("stall_d0_hwdata", 64'(bus.hwdata_o), 64'(8'h41));
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("stall_hwdata", 64'(bus.hwdata_o), 64'(8'h41));
      chk("stall_rdy",    64'(req_ready),    64'(0));
      chk("stall_hsel",   64'(bus.hsel_o),   64'(1));
    end
    bus.hready_i = 1'b1;
    tick();
    chk("stall_done_hsel", 64'(bus.hsel_o), 64'(0));

    // RX read
    rx_req       = 1'b1;
    bus.hrdata_i = 32'h0000_005A;
    tick();
    tick();
    chk_addr("rx_a", BASE, 1'b0);
    rx_req = 1'b0;
    tick();
    chk("rx_d_rxv", 64'(rx_valid), 64'(0));
    tick();
    chk("rx_gap_rxv", 64'(rx_valid), 64'(1));
    chk("rx_gap_rxd", 64'(rx_data),  64'(8'h5A));
    tick();
    chk("rx_idle_rxv", 64'(rx_valid), 64'(0));
    chk("rx_idle_rxd", 64'(rx_data),  64'(8'h5A));

    // Baud reprogram during a TX data phase jumps ahead of pending RX/TX
    req_valid = 2'b01;
    tick();
    chk("cfg_tx_a_rdy", 64'(req_ready), 64'(2'b01));
    tick();
    chk("cfg_tx_d_hwdata", 64'(bus.hwdata_o), 64'(8'h41));
    cfg_we    = 1'b1;
    cfg_baud  = 32'h1B;
    req_valid = 2'b11;
    rx_req    = 1'b1;
    tick();
    cfg_we = 1'b0;
    tick();
    tick();
    chk_addr("cfg_a", BASE + 32'h8, 1'b1);
    chk("cfg_a_init", 64'(init_done), 64'(1));
    tick();
    chk("cfg_d_hwdata", 64'(bus.hwdata_o), 64'(32'h1B));
    tick();
    tick();
    tick();
    chk_addr("cfg_rx_a", BASE, 1'b0);
    req_valid = 2'b00;
    rx_req    = 1'b0;

    // Error response in the read data phase is sticky
    tick();
    bus.hresp_i = 1'b1;
    tick();
    chk("hresp_err", 64'(err),      64'(1));
    chk("hresp_rxv", 64'(rx_valid), 64'(1));
    bus.hresp_i = 1'b0;
    req_valid   = 2'b01;
    tick();
    chk("err_sticky1", 64'(err), 64'(1));
    tick();
    chk("err_sticky2", 64'(err), 64'(1));
    chk("mid_a_rdy",   64'(req_ready), 64'(2'b01));

    // Reset in the middle of a data phase, then init repeats
    tick();
    chk("mid_d_htrans", 64'(bus.htrans_o), 64'(0));
    hreset    = 1'b1;
    req_valid = 2'b00;
    tick();
    chk_reset("rst2");
    hreset = 1'b0;
    tick();
    chk_addr("reinit_a", BASE + 32'h8, 1'b1);
    tick();
    chk("reinit_d_hwdata", 64'(bus.hwdata_o), 64'(32'h1B2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_uart_sched.md
Name: ahb_uart_sched

Overview:
- AHB-lite single-master sequencer that owns the AHB UART peripheral and shares it between requesters.
- After reset it programs the baud divisor (offset 0x8) and the control register (offset 0x4).
- It then serves byte-transmit requests from NREQ requesters with round-robin arbitration, plus on-demand RX reads, as single NONSEQ word transfers to the DATA register (offset 0x0).
- It sits between the SoC debug/print sources and the UART slave port, point-to-point with no bus matrix.

Parameters:
- NREQ, 2, number of TX byte requesters (1..8)
- AWIDTH, 32, AHB address width
- DWIDTH, 32, AHB data width
- BASE_ADDR, 32'h3000_0000, UART base address; low 4 bits zero
- BAUD_INIT, 32'h1B2, divisor written at init (115200 baud at 50 MHz)
- CTRL_INIT, 8'h03, control value written at init (rx_en=1, tx_en=1)

Ports:
- hclk in 1: the block's single clock
- hreset in 1: reset; the block has one clock, and reset is synchronous and active-high
- hsel_o out 1: slave select
- haddr_o out AWIDTH: address
- hwrite_o out 1: write flag
- hsize_o out 3: always 3'b010
- hburst_o out 3: always 3'b000 (SINGLE)
- htrans_o out 2: IDLE (2'b00) or NONSEQ (2'b10)
- hwdata_o out DWIDTH: write data, valid in data phase
- hready_i in 1: slave hreadyout
- hresp_i in 1: slave hresp (1 = ERROR)
- hrdata_i in DWIDTH: read data
- req_valid_i in NREQ: requester n has a byte
- req_data_i in 8*NREQ: byte n in bits [8n+7:8n]
- req_ready_o out NREQ: one-hot one-cycle pulse; byte accepted
- rx_req_i in 1: level; request one RX byte read
- rx_valid_o out 1: one-cycle pulse; rx_data_o valid
- rx_data_o out 8: received byte, held until next rx_valid_o
- cfg_we_i in 1: pulse; reprogram baud divisor
- cfg_baud_i in 32: new divisor
- init_done_o out 1: set after the init CTRL write completes
- busy_o out 1: FSM not in IDLE
- err_o out 1: sticky; set when hresp_i=1 in a data phase

Behaviour:
- Reset (sync, hreset=1 at an edge):
  - Output values: hsel_o=0, htrans_o=IDLE, haddr_o=0, hwrite_o=0, hwdata_o=0, req_ready_o=0, rx_valid_o=0, rx_data_o=0, init_done_o=0, err_o=0, busy_o=0.
  - Internal state: state=IDLE, pend_baud=1 with baud_q=BAUD_INIT, pend_ctrl=1, rr pointer=NREQ-1.
  - Reset mid-transfer abandons the transfer immediately and re-runs init.
- FSM states: IDLE, ADDR, DATA, GAP.
- IDLE:
  - Selects a job by fixed priority: pend_baud (write baud_q to BASE+8), then pend_ctrl (write CTRL_INIT to BASE+4), then rx_req_i (read BASE+0), then TX round-robin grant (write BASE+0).
  - No job: stay in IDLE.
  - TX jobs wait until init_done_o=1; RX jobs do not.
- ADDR (exactly 1 cycle):
  - Drives hsel_o=1, htrans_o=NONSEQ, haddr_o and hwrite_o for the job.
  - For a TX grant, req_ready_o[g] pulses in this cycle and the byte is latched.
  - Moves to DATA.
- DATA:
  - Drives hsel_o=1, htrans_o=IDLE, hwdata_o={24'b0,byte} or the register value.
  - Waits while hready_i=0, with no timeout (slave stalls on full TX FIFO or empty RX FIFO).
  - On hready_i=1, the transfer completes:
    - Read job: rx_data_o<=hrdata_i[7:0] and rx_valid_o pulses the following cycle.
    - Baud job: clears pend_baud.
    - Ctrl job: clears pend_ctrl and sets init_done_o.
    - If hresp_i=1: sets err_o; the job still counts as complete.
  - Moves to GAP.
- GAP (exactly 1 cycle):
  - hsel_o=0, htrans_o=IDLE; the slave requires hsel low between transfers.
  - Moves to IDLE.
- Minimum transfer time: 4 cycles from IDLE to IDLE, so sustained TX throughput is 1 byte per 4 cycles.
- Round robin:
  - Search starts at rr+1 modulo NREQ; the first requester with req_valid_i set wins.
  - rr is updated to the winner at grant time.
  - Fairness: a continuously requesting source waits at most NREQ-1 grants.
- cfg_we_i:
  - Latches cfg_baud_i into baud_q and sets pend_baud at any state.
  - If the FSM is mid-transfer, the write is issued at the next IDLE.
  - Back-to-back pulses: the last value wins.
  - cfg_we_i together with a pending baud job in ADDR: the new value is kept and pend_baud stays set.
  - init_done_o is unaffected.
- A requester may drop req_valid_i before its grant; no byte is sent for it.
- busy_o=(state!=IDLE).

Decomposition:
- Shared package ahb_uart_pkg holds:
  - HTRANS_IDLE/NONSEQ, HBURST_SINGLE, HSIZE_WORD
  - UART_DATA/CTRL/BAUD offsets (4'h0/4'h4/4'h8)
  - state encoding
  - job-kind encoding (BAUD, CTRL, RD, WR)
- One sub-module, rr_arbiter: NREQ-wide round-robin grant with pointer update on an enable input.

Test Plan:
- Reset release, hready_i=1 -> write 0x1B2 to BASE+8 at cycle 1, then write 0x03 to BASE+4 at cycle 5; init_done_o=1 after the second data phase; hsel_o=0 in each GAP.
- Both req_valid_i held, bytes 0x41/0x42, after init -> grants alternate 0,1,0,1; hwdata_o alternates 0x41/0x42; req_ready_o one-hot pulses 4 cycles apart.
- hready_i=0 for 10 data-phase cycles on a TX write -> hwdata_o stable, no req_ready_o pulses; transfer completes on the cycle hready_i rises.
- rx_req_i=1, hrdata_i=0x5A with hready_i=1 -> read of BASE+0 with hwrite_o=0; rx_valid_o pulses once with rx_data_o=0x5A.
- cfg_we_i with 0x1B during a TX data phase -> next transfer is a write of 0x1B to BASE+8, ahead of the pending TX and RX jobs.
- hresp_i=1 in a data phase -> err_o=1 and stays 1; hreset asserted mid-DATA -> all outputs at reset values next cycle and the init sequence repeats.
